fft_bram_arbiter: RTL
=====================

FFT_BRAM_ARBITER -- requirements
Module: fft_bram_arbiter

Interface
REQ-001 Parameter FRAME_WORDS, default 8: writer beats per frame; bank swaps after this many writes.
REQ-002 Parameter ADDR_W, default 13: byte-address width inside one bank.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 wr_addr  in  32  writer byte address; only [ADDR_W-1:0] used.
REQ-006 wr_din_re / wr_din_im  in  32 each  writer real / imaginary data.
REQ-007 wr_we  in  4  writer byte enables; wr_en  in  1  writer port enable.
REQ-008 rd_req_valid  in  1 / rd_req_ready  out  1 / rd_req_addr  in  ADDR_W  reader request channel.
REQ-009 rd_rvalid  out  1 / rd_rready  in  1 / rd_data_re, rd_data_im  out  32 each  reader response channel.
REQ-010 bram_addr  out  32 / bram_din_re, bram_din_im  out  32 / bram_we  out  4 / bram_en  out  1  shared BRAM port.
REQ-011 bram_dout_re, bram_dout_im  in  32  BRAM read data; 1-cycle read latency.
REQ-012 wr_bank  out  1  bank currently written; reader always targets ~wr_bank as sampled at request accept.
REQ-013 frame_done  out  1  one-cycle pulse on final write of a frame.
REQ-014 rd_stall_cnt  out  16  reader-blocked cycle counter (see Configuration).

Function
REQ-020 Write beat = wr_en && (wr_we != 0); wr_en with wr_we == 0 shall be ignored and not counted.
REQ-021 Writer has absolute priority and is never stalled; a write beat in cycle t drives bram_en=1, bram_we=wr_we, bram_addr={0, wr_bank, wr_addr[ADDR_W-1:0]}, bram_din=wr_din in cycle t+1 (all BRAM outputs registered).
REQ-022 rd_req_ready shall equal (state==IDLE) && !write beat, combinationally.
REQ-023 Reader FSM states IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
REQ-024 IDLE: on rd_req_valid && rd_req_ready, latch bank=~wr_bank and address; go ISSUE.
REQ-025 ISSUE: drive bram_en=1, bram_we=0, bram_addr={0, latched bank, latched addr}; go CAPTURE.
REQ-026 CAPTURE: register bram_dout_re/im into rd_data_re/im; go RESP.
REQ-027 RESP: rd_rvalid=1 with stable data until rd_rready; on handshake go IDLE; next request accepted the following cycle at the earliest.
REQ-028 A write beat arriving while reader is in ISSUE/CAPTURE/RESP shall proceed unmodified; port conflict is impossible by REQ-022.
REQ-029 Frame counter, width clog2(FRAME_WORDS), increments per write beat; at FRAME_WORDS-1 it wraps to 0, wr_bank toggles, and frame_done pulses coincident with that write on the BRAM port.
REQ-030 Bank swap during an outstanding read shall not alter that read's latched bank.
REQ-031 When no write or ISSUE occurs, bram_en=0, bram_we=0; bram_addr/din hold previous values.

Reset
REQ-040 rst high on a clock edge: state=IDLE, frame counter=0, wr_bank=0, frame_done=0, rd_rvalid=0, rd_data=0, bram_en=0, bram_we=0, bram_addr=0, bram_din=0, rd_stall_cnt=0.
REQ-041 Reset mid-read shall drop the outstanding read with no response; reset mid-frame discards the partial frame count.
REQ-042 rd_req_ready shall be 0 while rst is high.

Configuration
REQ-050 Macro FBA_STALL_CNT_EN defined: rd_stall_cnt increments each cycle rd_req_valid=1, state=IDLE and a write beat blocks acceptance; saturates at 0xFFFF; cleared only by rst.
REQ-051 Macro FBA_STALL_CNT_EN undefined: counter logic absent; rd_stall_cnt tied to 0; port retained.

Verification
REQ-060 8 back-to-back write beats, addr 0x0000..0x001C step 4, we=0xF -> 8 BRAM writes at t+1 with bank bit 0, frame_done pulses with 8th, wr_bank becomes 1.
REQ-061 After REQ-060, read request addr 0x0008 with BRAM returning re=0x00ABCDEF, im=0xFFF12345 -> ISSUE addr bit13=0, rd_rvalid 3 cycles after accept with those values.
REQ-062 rd_req_valid held during 5 consecutive write beats -> rd_req_ready=0 for those 5 cycles, accept on 6th; rd_stall_cnt=5 with FBA_STALL_CNT_EN, 0 without.
REQ-063 rd_rready held low 10 cycles in RESP while writes continue -> rd_data stable, writes unaffected, no new accept.
REQ-064 Request accepted at frame write 7 of 8, bank swaps next cycle -> read still issued to latched bank.
REQ-065 rst asserted during CAPTURE -> next cycle rd_rvalid=0, state IDLE, wr_bank=0, no response emitted.

Source files
------------

// File: rtl/fft_bram_arbiter.sv
`default_nettype none
// ============================================================================
// fft_bram_arbiter
//   Shares one BRAM port between a ping-pong frame writer (absolute priority)
//   and a single-outstanding reader of the opposite bank.
//   Optional feature macro: FBA_STALL_CNT_EN (reader stall counter).
// Revision: 1.0
// ============================================================================
module fft_bram_arbiter #(
    parameter int FRAME_WORDS = 8,
    parameter int ADDR_W      = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       wr_addr,
    input  logic [31:0]       wr_din_re,
    input  logic [31:0]       wr_din_im,
    input  logic [3:0]        wr_we,
    input  logic              wr_en,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    output logic              rd_rvalid,
    input  logic              rd_rready,
    output logic [31:0]       rd_data_re,
    output logic [31:0]       rd_data_im,
    output logic [31:0]       bram_addr,
    output logic [31:0]       bram_din_re,
    output logic [31:0]       bram_din_im,
    output logic [3:0]        bram_we,
    output logic              bram_en,
    input  logic [31:0]       bram_dout_re,
    input  logic [31:0]       bram_dout_im,
    output logic              wr_bank,
    output logic              frame_done,
    output logic [15:0]       rd_stall_cnt
);

    localparam int c_CNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int c_PAD_W = 32 - ADDR_W - 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_wbeat;
    logic                w_accept;
    logic                w_last;
    logic [c_CNT_W-1:0]  r_frame_cnt;
    logic                r_wr_bank;
    logic                r_frame_done;
    logic [31:0]         r_rd_data_re;
    logic [31:0]         r_rd_data_im;
    logic [31:0]         r_bram_addr;
    logic [31:0]         r_bram_din_re;
    logic [31:0]         r_bram_din_im;
    logic [3:0]          r_bram_we;
    logic                r_bram_en;
    logic                w_unused;

    assign w_unused     = &{1'b0, wr_addr[31:ADDR_W]};
    assign w_wbeat      = wr_en && (wr_we != 4'd0);
    assign rd_req_ready = (r_state == S_IDLE) && !w_wbeat && !rst;
    assign w_accept     = rd_req_valid && rd_req_ready;
    assign w_last       = (r_frame_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_state_nxt = S_ISSUE;
            S_ISSUE:   w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_RESP;
            S_RESP:    if (rd_rready) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // The read address is registered at accept so it is on the port during
    // ISSUE; the bank is fixed at that instant, so a later swap cannot move it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt   <= '0;
            r_wr_bank     <= 1'b0;
            r_frame_done  <= 1'b0;
            r_rd_data_re  <= '0;
            r_rd_data_im  <= '0;
            r_bram_addr   <= '0;
            r_bram_din_re <= '0;
            r_bram_din_im <= '0;
            r_bram_we     <= '0;
            r_bram_en     <= 1'b0;
        end else begin
            r_frame_done <= w_wbeat && w_last;
            if (w_wbeat) begin
                r_frame_cnt <= w_last ? '0 : r_frame_cnt + c_CNT_W'(1);
                if (w_last) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end

            if (w_wbeat) begin
                r_bram_en     <= 1'b1;
                r_bram_we     <= wr_we;
                r_bram_addr   <= {{c_PAD_W{1'b0}}, r_wr_bank, wr_addr[ADDR_W-1:0]};
                r_bram_din_re <= wr_din_re;
                r_bram_din_im <= wr_din_im;
            end else if (w_accept) begin
                r_bram_en   <= 1'b1;
                r_bram_we   <= 4'd0;
                r_bram_addr <= {{c_PAD_W{1'b0}}, ~r_wr_bank, rd_req_addr};
            end else begin
                r_bram_en <= 1'b0;
                r_bram_we <= 4'd0;
            end

            if (r_state == S_CAPTURE) begin
                r_rd_data_re <= bram_dout_re;
                r_rd_data_im <= bram_dout_im;
            end
        end
    end

`ifdef FBA_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (rd_req_valid && (r_state == S_IDLE) && w_wbeat
                     && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign rd_stall_cnt = r_stall_cnt;
`else
    assign rd_stall_cnt = 16'd0;
`endif

    assign rd_rvalid   = (r_state == S_RESP);
    assign rd_data_re  = r_rd_data_re;
    assign rd_data_im  = r_rd_data_im;
    assign bram_addr   = r_bram_addr;
    assign bram_din_re = r_bram_din_re;
    assign bram_din_im = r_bram_din_im;
    assign bram_we     = r_bram_we;
    assign bram_en     = r_bram_en;
    assign wr_bank     = r_wr_bank;
    assign frame_done  = r_frame_done;

endmodule
`default_nettype wire
